// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM states and round helper functions
// Purpose: round count, Rcon table, FSM state enum and byte-level helpers.
// Ports: none (package).
package aes_pkg;

  localparam int NR = 10;

  // Indexed by round number 1..10; unused slots are zero so any 4-bit index is safe.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1B, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic {IDLE, ROUND} fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  // Byte k lives at bits [127-8k -: 8]; state[r][c] is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    mix_columns = o;
  endfunction

endpackage

// File: rtl/aes_enc_if.sv
// rtl/aes_enc_if.sv - request/result bundle between a host and the AES encrypt core
// Purpose: groups start/plaintext/local_key requests and cipher_text/done/busy results.
// Ports: master drives start, plaintext, local_key; slave drives cipher_text, done, busy.
interface aes_enc_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] local_key;
  logic [127:0] cipher_text;
  logic         done;
  logic         busy;

  modport master (output start, plaintext, local_key,
                  input  cipher_text, done, busy);
  modport slave  (input  start, plaintext, local_key,
                  output cipher_text, done, busy);
endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
// Purpose: S(a) = affine(a^-1 in GF(2^8)/0x11B), with 0 mapping to 0x63.
// Ports: a_i (byte in), s_o (substituted byte out).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    gmul = p;
  endfunction

  // Inverse as a^254 (square-and-multiply over exponent 8'b1111_1110); 0 stays 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, a);
    end
    ginv = r;
  endfunction

  logic [7:0] inv;

  assign inv = ginv(a_i);
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_enc.sv
// rtl/aes_enc.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
// Purpose: accepts a block when idle, runs 10 rounds, pulses done with registered cipher_text.
// Ports: clk, rest (sync active-low reset), bus (aes_enc_if.slave: start, plaintext,
//        local_key in; cipher_text, done, busy out).
module aes_enc
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      rest,
  aes_enc_if.slave  bus
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;

  logic [127:0] sb;
  logic [31:0]  rw;
  logic [31:0]  sw;
  logic [31:0]  t, w0, w1, w2, w3;
  logic [127:0] rk_next;
  logic [127:0] sr;
  logic [127:0] round_out;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (.a_i(st_q[8*i +: 8]), .s_o(sb[8*i +: 8]));
  end

  assign rw = rot_word(rk_q[31:0]);

  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    aes_sbox u_sbox (.a_i(rw[8*j +: 8]), .s_o(sw[8*j +: 8]));
  end

  assign t  = sw ^ {RCON[rnd_q], 24'h0};
  assign w0 = rk_q[127:96] ^ t;
  assign w1 = rk_q[95:64]  ^ w0;
  assign w2 = rk_q[63:32]  ^ w1;
  assign w3 = rk_q[31:0]   ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  assign sr = shift_rows(sb);
  // Final round skips MixColumns.
  assign round_out = ((rnd_q == 4'(NR)) ? sr : mix_columns(sr)) ^ rk_next;

  always_comb begin
    fsm_d  = fsm_q;
    rnd_d  = rnd_q;
    st_d   = st_q;
    rk_d   = rk_q;
    ct_d   = ct_q;
    done_d = 1'b0;
    busy_d = busy_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          st_d   = bus.plaintext ^ bus.local_key;
          rk_d   = bus.local_key;
          rnd_d  = 4'd1;
          busy_d = 1'b1;
          fsm_d  = ROUND;
        end
      end
      ROUND: begin
        st_d = round_out;
        rk_d = rk_next;
        if (rnd_q == 4'(NR)) begin
          ct_d   = round_out;
          done_d = 1'b1;
          busy_d = 1'b0;
          rnd_d  = 4'd0;
          fsm_d  = IDLE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      fsm_q  <= IDLE;
      rnd_q  <= 4'd0;
      st_q   <= '0;
      rk_q   <= '0;
      ct_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      st_q   <= st_d;
      rk_q   <= rk_d;
      ct_q   <= ct_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.cipher_text = ct_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_aes_enc.sv
// tb/tb_aes_enc.sv - scoreboard bench for aes_enc using FIPS-197 vectors
module tb_aes_enc;

  localparam logic [127:0] KEY_B  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_B   = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] CT_B   = 128'h3925841D02DC09FBDC118597196A0B32;
  localparam logic [127:0] KEY_P  = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] PT_P   = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] CT_P   = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] CT_C   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] CT_Z   = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;

  logic clk = 1'b0;
  logic rest = 1'b0;
  always #5 clk = ~clk;

  aes_enc_if bus();
  aes_enc dut (.clk(clk), .rest(rest), .bus(bus));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", {127'b0, bus.done}, 128'h0);
      else check("cipher_text", bus.cipher_text, exp_q.pop_front());
    end
  end

  // Drive one request; returns #1 after the accepting edge (that edge counts as edge 1).
  task automatic launch(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] exp);
    bus.local_key = key;
    bus.plaintext = pt;
    bus.start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_accept", {127'b0, bus.busy}, 128'h1);
  endtask

  task automatic wait_done(input string tag, input int n0, input int exp_n);
    int n;
    n = n0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 128'(n), 128'(exp_n));
  endtask

  int d0;

  initial begin
    bus.start = 1'b0;
    bus.plaintext = '0;
    bus.local_key = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {127'b0, bus.busy}, 128'h0);
    check("rst_done", {127'b0, bus.done}, 128'h0);
    check("rst_ct", bus.cipher_text, 128'h0);
    rest = 1'b1;
    @(posedge clk);
    #1;

    launch(KEY_B, PT_B, CT_B);
    wait_done("lat_app_b", 1, 11);
    @(posedge clk); #1;

    launch(KEY_P, PT_P, CT_P);
    wait_done("lat_pair", 1, 11);
    @(posedge clk); #1;

    // Ignored start and plaintext change mid-block.
    d0 = done_cnt;
    launch(KEY_C, PT_C, CT_C);
    repeat (4) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.plaintext = '1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("lat_c1", 6, 11);
    repeat (15) begin @(posedge clk); #1; end
    check("c1_single_done", 128'(done_cnt - d0), 128'h1);
    check("c1_idle_busy", {127'b0, bus.busy}, 128'h0);

    // Back-to-back with start held high.
    bus.local_key = KEY_B;
    bus.plaintext = PT_B;
    exp_q.push_back(CT_B);
    exp_q.push_back(CT_B);
    bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done("b2b_first", 1, 11);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_restart_busy", {127'b0, bus.busy}, 128'h1);
    wait_done("b2b_second", 1, 11);
    @(posedge clk); #1;

    // Reset abort at round 5.
    d0 = done_cnt;
    bus.local_key = KEY_C;
    bus.plaintext = PT_C;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rest = 1'b0;
    @(posedge clk); #1;
    rest = 1'b1;
    check("abort_busy", {127'b0, bus.busy}, 128'h0);
    check("abort_ct", bus.cipher_text, 128'h0);
    check("abort_done", {127'b0, bus.done}, 128'h0);
    repeat (15) begin @(posedge clk); #1; end
    check("abort_no_done", 128'(done_cnt - d0), 128'h0);

    launch(KEY_C, PT_C, CT_C);
    wait_done("lat_after_abort", 1, 11);
    @(posedge clk); #1;

    launch(128'h0, 128'h0, CT_Z);
    wait_done("lat_zero", 1, 11);
    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_empty", 128'(exp_q.size()), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
